// File: rtl/compute_ram_pkg.sv
// compute_ram_pkg: constants and types shared by the compute-RAM front-end blocks.
//
// Contents:
//   BRAM_AWIDTH / BRAM_DWIDTH / BRAM_DEPTH / COMPUTE_DWIDTH  memory and operand geometry
//   CNT_WIDTH                                                 pair counter width (0..BRAM_DEPTH)
//   OP_A_LSB / OP_B_LSB                                       operand positions in a BRAM word
//   loader_state_e                                            operand_loader FSM states
//   pack_operands()                                           builds a BRAM word from A and B
package compute_ram_pkg;

    localparam int unsigned BRAM_AWIDTH    = 9;
    localparam int unsigned BRAM_DWIDTH    = 40;
    localparam int unsigned COMPUTE_DWIDTH = 8;
    localparam int unsigned BRAM_DEPTH     = 512;
    // One extra bit so a full-depth job (BRAM_DEPTH pairs) is representable.
    localparam int unsigned CNT_WIDTH      = $clog2(BRAM_DEPTH) + 1;

    localparam int unsigned OP_A_LSB = 0;
    localparam int unsigned OP_B_LSB = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StGap,
        StRun
    } loader_state_e;

    function automatic logic [BRAM_DWIDTH-1:0] pack_operands(
        input logic [COMPUTE_DWIDTH-1:0] a,
        input logic [COMPUTE_DWIDTH-1:0] b
    );
        logic [BRAM_DWIDTH-1:0] word;
        word = '0;
        word[OP_A_LSB +: COMPUTE_DWIDTH] = a;
        word[OP_B_LSB +: COMPUTE_DWIDTH] = b;
        return word;
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: operand stream handshake plus the external BRAM write port.
//
// Signals:
//   s_valid, s_a, s_b   host -> loader operand pair
//   s_ready             loader -> host, registered
//   external, bram_sel  external BRAM path select / port select
//   bram_addr_ext, bram_wdata_ext, bram_wren_ext   external BRAM write
//
// Modports:
//   slave   the loader's view (consumes the stream, drives the BRAM port)
//   master  the host/bench view (drives the stream, observes everything else)
interface operand_loader_if;

    logic                                       s_valid;
    logic                                       s_ready;
    logic [compute_ram_pkg::COMPUTE_DWIDTH-1:0] s_a;
    logic [compute_ram_pkg::COMPUTE_DWIDTH-1:0] s_b;

    logic                                       external;
    logic                                       bram_sel;
    logic [compute_ram_pkg::BRAM_AWIDTH-1:0]    bram_addr_ext;
    logic [compute_ram_pkg::BRAM_DWIDTH-1:0]    bram_wdata_ext;
    logic                                       bram_wren_ext;

    modport slave (
        input  s_valid, s_a, s_b,
        output s_ready, external, bram_sel, bram_addr_ext, bram_wdata_ext, bram_wren_ext
    );

    modport master (
        output s_valid, s_a, s_b,
        input  s_ready, external, bram_sel, bram_addr_ext, bram_wdata_ext, bram_wren_ext
    );

endinterface

// File: rtl/loader_addr_gen.sv
// loader_addr_gen: BRAM write pointer and remaining-word counter for operand_loader.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   load_i, load_ptr_i, load_cnt_i   start a job: set pointer and remaining count
//   reload_cnt_i, reload_val_i    replace the remaining count, pointer untouched
//   step_i                        one word issued: pointer +1 (wraps), count -1
//   ptr_o, cnt_o                  current pointer / remaining count
//   cnt_next_o                    remaining count after this cycle's update
module loader_addr_gen
    import compute_ram_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [BRAM_AWIDTH-1:0] load_ptr_i,
    input  logic [CNT_WIDTH-1:0]   load_cnt_i,
    input  logic                   reload_cnt_i,
    input  logic [CNT_WIDTH-1:0]   reload_val_i,
    input  logic                   step_i,
    output logic [BRAM_AWIDTH-1:0] ptr_o,
    output logic [CNT_WIDTH-1:0]   cnt_o,
    output logic [CNT_WIDTH-1:0]   cnt_next_o
);

    logic [BRAM_AWIDTH-1:0] ptr_d, ptr_q;
    logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            ptr_d = load_ptr_i;
            cnt_d = load_cnt_i;
        end else if (reload_cnt_i) begin
            cnt_d = reload_val_i;
        end else if (step_i) begin
            // Pointer width equals the address width, so 511 + 1 wraps to 0.
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign ptr_o      = ptr_q;
    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: packs streamed 8-bit operand pairs into 40-bit BRAM words, writes them
// through the compute-RAM system's external BRAM port, then holds `start` until `done_in`.
//
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   go                        one-cycle job request, honoured only when idle
//   cfg_start_addr, cfg_count first BRAM word and number of pairs (1..512), latched on go
//   bus_io (slave)            operand stream and external BRAM write port
//   start, done_in            system start level / system done pulse
//   busy                      high whenever not idle
//   run_done                  one-cycle pulse when the job completes
//
// Build option: define OPERAND_LOADER_ZERO_FILL_EN to add a FILL state that writes zero
// words after the operand pairs until all BRAM_DEPTH words of the job have been written.
module operand_loader
    import compute_ram_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   go,
    input  logic [BRAM_AWIDTH-1:0] cfg_start_addr,
    input  logic [CNT_WIDTH-1:0]   cfg_count,
    operand_loader_if.slave        bus_io,
    output logic                   start,
    input  logic                   done_in,
    output logic                   busy,
    output logic                   run_done
);

    loader_state_e state_q, state_d;

    logic                   s_ready_q, s_ready_d;
    logic                   external_q, external_d;
    logic [BRAM_AWIDTH-1:0] addr_q, addr_d;
    logic [BRAM_DWIDTH-1:0] wdata_q, wdata_d;
    logic                   wren_q, wren_d;
    logic                   start_q, start_d;
    logic                   run_done_q, run_done_d;

    logic [BRAM_AWIDTH-1:0] ptr;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   go_ok;
    logic                   accept;
    logic                   step;
    logic                   reload_cnt;
    logic [CNT_WIDTH-1:0]   fill_len;

    assign go_ok  = (state_q == StIdle) && go && (cfg_count != '0);
    assign accept = (state_q == StLoad) && s_ready_q && bus_io.s_valid;

`ifdef OPERAND_LOADER_ZERO_FILL_EN
    logic [CNT_WIDTH-1:0] job_cnt_q, job_cnt_d;

    assign job_cnt_d = go_ok ? cfg_count : job_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            job_cnt_q <= '0;
        end else begin
            job_cnt_q <= job_cnt_d;
        end
    end

    // Zero words still owed once every pair has been written.
    assign fill_len   = CNT_WIDTH'(BRAM_DEPTH) - job_cnt_q;
    // Final LOAD cycle: re-arm the counter for FILL; the pointer already sits on the next word.
    assign reload_cnt = (state_q == StLoad) && (cnt == '0);
    assign step       = accept || ((state_q == StFill) && (cnt != '0));
`else
    assign fill_len   = '0;
    assign reload_cnt = 1'b0;
    assign step       = accept;
`endif

    loader_addr_gen u_addr_gen (
        .clk_i        (clk),
        .rst_ni       (resetn),
        .load_i       (go_ok),
        .load_ptr_i   (cfg_start_addr),
        .load_cnt_i   (cfg_count),
        .reload_cnt_i (reload_cnt),
        .reload_val_i (fill_len),
        .step_i       (step),
        .ptr_o        (ptr),
        .cnt_o        (cnt),
        .cnt_next_o   (cnt_next)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. LOAD and FILL each keep one extra cycle after the last word is issued
    // (count already zero) so that word's registered write still sees external=1.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (go_ok) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (cnt == '0) begin
`ifdef OPERAND_LOADER_ZERO_FILL_EN
                    state_d = (fill_len != '0) ? StFill : StGap;
`else
                    state_d = StGap;
`endif
                end
            end
`ifdef OPERAND_LOADER_ZERO_FILL_EN
            StFill: begin
                if (cnt == '0) begin
                    state_d = StGap;
                end
            end
`endif
            StGap: begin
                state_d = StRun;
            end
            StRun: begin
                if (done_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs, all registered from the upcoming state so they line up with it.
    always_comb begin
        s_ready_d  = (state_d == StLoad) && (cnt_next != '0);
        external_d = (state_d == StLoad) || (state_d == StFill);
        wren_d     = step;
        addr_d     = step ? ptr : '0;
        wdata_d    = accept ? pack_operands(bus_io.s_a, bus_io.s_b) : '0;
        start_d    = (state_d == StRun);
        run_done_d = (state_q == StRun) && done_in;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_ready_q  <= 1'b0;
            external_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            start_q    <= 1'b0;
            run_done_q <= 1'b0;
        end else begin
            s_ready_q  <= s_ready_d;
            external_q <= external_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            start_q    <= start_d;
            run_done_q <= run_done_d;
        end
    end

    assign bus_io.s_ready        = s_ready_q;
    assign bus_io.external       = external_q;
    assign bus_io.bram_sel       = 1'b1;
    assign bus_io.bram_addr_ext  = addr_q;
    assign bus_io.bram_wdata_ext = wdata_q;
    assign bus_io.bram_wren_ext  = wren_q;
    assign start                 = start_q;
    assign busy                  = (state_q != StIdle);
    assign run_done              = run_done_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end stage that feeds the compute-RAM system. It accepts a stream of 8-bit operand pairs over a valid/ready handshake and packs each pair into a 40-bit BRAM word. It writes the words through the system's external BRAM port, then drives the system's `start` and holds it until the system pulses `done`. It sits between the host/DMA stream and the `system` top.

## Interface
- `BRAM_AWIDTH`, 9, BRAM address width.
- `BRAM_DWIDTH`, 40, BRAM word width.
- `COMPUTE_DWIDTH`, 8, operand width.
- `BRAM_DEPTH`, 512, BRAM words.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `go` in 1: one-cycle job request; sampled only in IDLE.
- `cfg_start_addr` in BRAM_AWIDTH: first BRAM word to write; latched on accepted `go`.
- `cfg_count` in BRAM_AWIDTH+1: number of pairs, 1..512; latched on `go`.
- `s_valid` in 1, `s_ready` out 1: operand stream handshake.
- `s_a` in COMPUTE_DWIDTH: operand A, packed to word bits [7:0].
- `s_b` in COMPUTE_DWIDTH: operand B, packed to word bits [15:8].
- `external` out 1: selects the external BRAM path.
- `bram_sel` out 1: external port select; constant 1 (port a).
- `bram_addr_ext` out BRAM_AWIDTH: external write address.
- `bram_wdata_ext` out BRAM_DWIDTH: write data.
- `bram_wren_ext` out 1: write enable.
- `start` out 1: system start, level.
- `done_in` in 1: system `done` pulse.
- `busy` out 1: high in any state other than IDLE.
- `run_done` out 1: one-cycle pulse when the job completes.

## Operation
- States: IDLE, LOAD, FILL (only with the macro), GAP, RUN.
- **IDLE**
  - All outputs are low except `bram_sel`.
  - `go` with `cfg_count` != 0: latch the address pointer and the remaining count, then go to LOAD.
  - `go` with `cfg_count` == 0: ignored; stay in IDLE.
- **LOAD**
  - `s_ready`=1 and `external`=1.
  - Each `s_valid & s_ready` handshake registers a write: addr = pointer, data = {24'b0, s_b, s_a}, wren = 1. The pointer increments and the count decrements.
  - The pointer wraps modulo 512 (511 → 0).
  - When the last pair is accepted, `s_ready` drops in the next cycle. The state moves to FILL if the macro is enabled, otherwise to GAP.
- **GAP**
  - One cycle with `external`=0 and `bram_wren_ext`=0. This gives the port mux a turnaround cycle before `start`.
  - Next state: RUN.
- **RUN**
  - `start`=1.
  - On `done_in`=1: clear `start`, pulse `run_done`, return to IDLE.
- `go` while `busy` is ignored.
- `s_valid` outside LOAD is ignored; no write occurs.
- `resetn` low at any point asynchronously clears all state and outputs, including mid-LOAD. A partially written BRAM is left as is.

## Timing
- Write latency: the handshake in cycle N produces `bram_wren_ext`/`addr`/`wdata` in cycle N+1, held for exactly one cycle.
- Throughput: one pair per cycle while `s_valid` is held.
- `s_ready` is registered and does not depend combinationally on `s_valid`.
- `external` rises in the cycle after the accepted `go`. It stays high through the last write cycle (and FILL), then is low in GAP.
- `start` rises in the cycle after GAP.
- `run_done` asserts in the cycle after `done_in` is sampled high.
- `start` is low in that same cycle. The system then clears its counters, since `~start` acts as its reset.
- Reset values: `s_ready`=0, `external`=0, `bram_sel`=1, `bram_addr_ext`=0, `bram_wdata_ext`=0, `bram_wren_ext`=0, `start`=0, `busy`=0, `run_done`=0.

## Configuration
- Macro: `OPERAND_LOADER_ZERO_FILL_EN`.
- Defined: FILL writes zero words at consecutive (wrapping) addresses, one per cycle, until 512 words in total have been written for the job. FILL is skipped if `cfg_count`=512.
- Undefined: no FILL state; LOAD goes straight to GAP. Unwritten words keep stale contents.

## Structure
- Shared package `compute_ram_pkg`:
  - width and depth constants (`BRAM_AWIDTH`, `BRAM_DWIDTH`, `BRAM_DEPTH`, `COMPUTE_DWIDTH`);
  - the state enum type;
  - the word-packing bit positions (A at [7:0], B at [15:8]).
- Sub-module `loader_addr_gen`: pointer and remaining-count registers with wrap, load, and decrement. The FSM stays in the top.

## Test plan
- `cfg_start_addr`=0, `cfg_count`=4, pairs (1,2),(3,4),(5,6),(7,8) streamed back-to-back → writes at addr 0..3 with data 0x0000000201, 0x0000000403, …; `start` rises 2 cycles after the last write.
- `cfg_start_addr`=510, `cfg_count`=3 → writes to 510, 511, 0.
- `s_valid` toggled every other cycle with `cfg_count`=2 → exactly 2 writes, each one cycle after its handshake; no write in idle cycles.
- In RUN, drive a one-cycle `done_in` → `start` low and `run_done`=1 in the next cycle; `busy`=0 after. A second `go` asserted during RUN → ignored.
- `resetn` pulsed low mid-LOAD after 2 of 5 pairs → all outputs at reset values immediately; a new `go` starts cleanly from the new `cfg_start_addr`.
- With `OPERAND_LOADER_ZERO_FILL_EN`, `cfg_start_addr`=100, `cfg_count`=2 → 2 data writes then 510 zero writes at 102..511, 0..99; then GAP, then `start`.
